// File: rtl/muxpga_pkg.sv
// Shared constants and types for the mux-FPGA configuration sequencer.
package muxpga_pkg;

    localparam int ROWS      = 5;
    localparam int COLS      = 3;
    localparam int CFG_WORDS = 24;

    localparam logic [1:0] CMD_SHIFT = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_HOLD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CAPTURE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/muxpga_cfg_sequencer_if.sv
// Host-facing handshakes of the sequencer: config nibble stream in, captured result out.
interface muxpga_cfg_sequencer_if;

    logic       cfg_valid;
    logic [3:0] cfg_data;
    logic       cfg_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;

    modport master (
        output cfg_valid, cfg_data, res_ready,
        input  cfg_ready, res_valid, res_data
    );

    modport slave (
        input  cfg_valid, cfg_data, res_ready,
        output cfg_ready, res_valid, res_data
    );

endinterface

// File: rtl/muxpga_seq_counter.sv
// Loadable down-counter shared by the LOAD word count and the RUN cycle count.
module muxpga_seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] r_count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_one  = (r_count == W'(1));

endmodule

// File: rtl/muxpga_cfg_sequencer.sv
// Loads the fabric config chain, runs the fabric run_cycles times and returns its output.
// Optional macro MUXPGA_SEQ_CHECKSUM_EN adds cfg_sum (XOR of nibbles accepted in the last LOAD).
module muxpga_cfg_sequencer #(
    parameter int CFG_WORDS = 24,
    parameter int RUN_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  keep_cfg,
    input  logic [RUN_W-1:0]      run_cycles,
    muxpga_cfg_sequencer_if.slave host,
    input  logic [3:0]            op_nibble,
    output logic [1:0]            fab_cmd,
    output logic [3:0]            fab_nibble,
    input  logic [7:0]            fab_out,
    output logic                  busy
`ifdef MUXPGA_SEQ_CHECKSUM_EN
    ,
    output logic [3:0]            cfg_sum
`endif
);

    import muxpga_pkg::*;

    localparam int CNT_W = (RUN_W > $clog2(CFG_WORDS + 1)) ? RUN_W : $clog2(CFG_WORDS + 1);

    seq_state_t       r_state;
    logic [1:0]       r_fab_cmd;
    logic [3:0]       r_fab_nibble;
    logic             r_res_valid;
    logic [7:0]       r_res_data;
    logic [RUN_W-1:0] r_run_len;

    logic             w_cfg_ready;
    logic             w_cfg_accept;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_value;
    logic             w_cnt_zero;
    logic             w_cnt_one;

    // In LOAD the counter holds the words still to accept, so zero means the chain is full.
    assign w_cfg_ready  = (r_state == ST_LOAD) && !w_cnt_zero;
    assign w_cfg_accept = host.cfg_valid && w_cfg_ready;

    assign host.cfg_ready = w_cfg_ready;
    assign host.res_valid = r_res_valid;
    assign host.res_data  = r_res_data;
    assign fab_cmd        = r_fab_cmd;
    assign fab_nibble     = r_fab_nibble;
    assign busy           = (r_state != ST_IDLE);

    // Word count on entry to LOAD, cycle count on entry to RUN (from IDLE or from LOAD).
    always_comb begin
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_cnt_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = keep_cfg ? CNT_W'(run_cycles) : CNT_W'(CFG_WORDS);
                end
            end
            ST_LOAD: begin
                if (w_cnt_zero) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = CNT_W'(r_run_len);
                end else begin
                    w_cnt_dec = w_cfg_accept;
                end
            end
            ST_RUN:  w_cnt_dec = 1'b1;
            default: ;
        endcase
    end

    muxpga_seq_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .i_dec   (w_cnt_dec),
        .o_zero  (w_cnt_zero),
        .o_one   (w_cnt_one)
    );

    // CAPTURE keeps fab_cmd at RUN, but its evaluation edge lands after fab_out is sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_fab_cmd    <= CMD_HOLD;
            r_fab_nibble <= 4'h0;
            r_res_valid  <= 1'b0;
            r_res_data   <= 8'h00;
            r_run_len    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fab_cmd <= CMD_HOLD;
                    if (start) begin
                        r_run_len <= run_cycles;
                        if (!keep_cfg) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_fab_cmd    <= CMD_RUN;
                            r_fab_nibble <= op_nibble;
                            r_state      <= (run_cycles == '0) ? ST_CAPTURE : ST_RUN;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_cnt_zero) begin
                        r_fab_cmd    <= CMD_RUN;
                        r_fab_nibble <= op_nibble;
                        r_state      <= (r_run_len == '0) ? ST_CAPTURE : ST_RUN;
                    end else if (w_cfg_accept) begin
                        r_fab_cmd    <= CMD_SHIFT;
                        r_fab_nibble <= host.cfg_data;
                    end else begin
                        r_fab_cmd <= CMD_HOLD;
                    end
                end
                ST_RUN: begin
                    r_fab_cmd    <= CMD_RUN;
                    r_fab_nibble <= op_nibble;
                    if (w_cnt_one) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_fab_cmd   <= CMD_HOLD;
                    r_res_data  <= fab_out;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_fab_cmd <= CMD_HOLD;
                    if (host.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MUXPGA_SEQ_CHECKSUM_EN
    logic [3:0] r_cfg_sum;

    // A keep_cfg job leaves the sum of the config that is still loaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_sum <= 4'h0;
        end else if ((r_state == ST_IDLE) && start && !keep_cfg) begin
            r_cfg_sum <= 4'h0;
        end else if (w_cfg_accept) begin
            r_cfg_sum <= r_cfg_sum ^ host.cfg_data;
        end
    end

    assign cfg_sum = r_cfg_sum;
`endif

endmodule

// File: tb/tb_muxpga_cfg_sequencer.sv
// Self-checking bench for muxpga_cfg_sequencer with a behavioural fabric stand-in.
// Build with MUXPGA_SEQ_CHECKSUM_EN to also check cfg_sum.
module tb_muxpga_cfg_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       keep_cfg;
    logic [7:0] run_cycles;
    logic [3:0] op_nibble;
    logic [1:0] fab_cmd;
    logic [3:0] fab_nibble;
    logic [7:0] fab_out;
    logic       busy;
`ifdef MUXPGA_SEQ_CHECKSUM_EN
    logic [3:0] cfg_sum;
`endif

    int checkCount = 0;
    int errorCount = 0;

    logic [3:0] bits [24];
    logic [7:0] modelOut   = 8'h00;
    logic [3:0] modelXor   = 4'h0;
    logic [3:0] modelSum   = 4'h0;
    bit         chainValid = 1'b0;
    logic [7:0] lastRes;
    logic [7:0] prevRes;
    int         rstSent;
    int         rstCycles;

    muxpga_cfg_sequencer_if hostIf ();

    muxpga_cfg_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .keep_cfg   (keep_cfg),
        .run_cycles (run_cycles),
        .host       (hostIf),
        .op_nibble  (op_nibble),
        .fab_cmd    (fab_cmd),
        .fab_nibble (fab_nibble),
        .fab_out    (fab_out),
        .busy       (busy)
`ifdef MUXPGA_SEQ_CHECKSUM_EN
        ,
        .cfg_sum    (cfg_sum)
`endif
    );

    always #5 clk = ~clk;

    // Fabric stand-in: a 24-nibble shift chain, and a run step that shifts in nibble ^ XOR(chain).
    logic [3:0] fabChain [24] = '{default: 4'h0};
    logic [7:0] fabOut = 8'h00;
    logic [3:0] chainX;

    always @* begin
        chainX = 4'h0;
        for (int i = 0; i < 24; i++) chainX = chainX ^ fabChain[i];
    end

    always @(posedge clk) begin
        if (fab_cmd == 2'd0) begin
            for (int i = 23; i > 0; i--) fabChain[i] <= fabChain[i-1];
            fabChain[0] <= fab_nibble;
        end else if (fab_cmd == 2'd1) begin
            fabOut <= {fabOut[3:0], fab_nibble ^ chainX};
        end
    end

    assign fab_out = fabOut;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic finishRun();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    endtask

    // One complete job; validMode 0 = back-to-back, 1 = every other cycle, 2 = random.
    task automatic applyStimulus(input bit keep, input int nRuns, input int validMode,
                                 input logic [3:0] opn, input int holdCycles, input bit pulseStart);
        int         sent;
        int         shiftSeen;
        int         runSeen;
        int         readyBad;
        int         cycles;
        bit         prevAccept;
        bit         prevOffer;
        bit         v;
        logic [3:0] lastNib;
        logic [3:0] xr;
        logic [7:0] exp;
        sent = 0; shiftSeen = 0; runSeen = 0; readyBad = 0; cycles = 0;
        prevAccept = 1'b0; prevOffer = 1'b0; lastNib = 4'h0;

        checkOutput("idleBusy", busy, 0);
        op_nibble  = opn;
        keep_cfg   = keep;
        run_cycles = 8'(nRuns);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        keep_cfg   = ~keep;
        run_cycles = 8'($urandom);
        checkOutput("busyStart", busy, 1);

        while (!hostIf.res_valid && cycles < 2000) begin
            if (prevAccept) begin
                checkOutput("shiftCmd", fab_cmd, 0);
                checkOutput("shiftNibble", fab_nibble, lastNib);
            end else if (prevOffer) begin
                checkOutput("holdCmd", fab_cmd, 2);
            end
            if (fab_cmd == 2'd0) shiftSeen++;
            if (fab_cmd == 2'd1) runSeen++;
            if (hostIf.cfg_ready && (keep || sent >= 24)) readyBad++;
            if (!keep && sent < 24) begin
                case (validMode)
                    0:       v = 1'b1;
                    1:       v = (cycles % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                hostIf.cfg_valid = v;
                hostIf.cfg_data  = v ? bits[sent] : 4'($urandom);
            end else begin
                hostIf.cfg_valid = 1'($urandom_range(0, 1));
                hostIf.cfg_data  = 4'($urandom);
            end
            prevAccept = hostIf.cfg_valid && hostIf.cfg_ready;
            prevOffer  = hostIf.cfg_ready && !hostIf.cfg_valid;
            if (prevAccept) begin
                lastNib = hostIf.cfg_data;
                sent++;
            end
            start = pulseStart && (fab_cmd == 2'd1);
            @(negedge clk);
            cycles++;
        end
        start            = 1'b0;
        hostIf.cfg_valid = 1'b0;
        if (!hostIf.res_valid) begin
            checkOutput("resValidTimeout", hostIf.res_valid, 1);
            finishRun();
        end

        if (!keep) begin
            xr = 4'h0;
            for (int i = 0; i < 24; i++) xr = xr ^ bits[i];
            modelXor   = xr;
            modelSum   = xr;
            chainValid = 1'b1;
        end
        exp = modelOut;
        for (int k = 0; k < nRuns; k++) exp = {exp[3:0], opn ^ modelXor};
        modelOut = {exp[3:0], opn ^ modelXor};

        checkOutput("shiftCount", shiftSeen, keep ? 0 : 24);
        checkOutput("runCount", runSeen, nRuns + 1);
        checkOutput("readyOutsideLoad", readyBad, 0);
        checkOutput("doneCmd", fab_cmd, 2);
        checkOutput("resData", hostIf.res_data, exp);
`ifdef MUXPGA_SEQ_CHECKSUM_EN
        checkOutput("cfgSum", cfg_sum, modelSum);
`endif
        if (!keep) begin
            for (int i = 0; i < 24; i++) checkOutput("chainOrder", fabChain[i], bits[23-i]);
        end

        lastRes = hostIf.res_data;
        hostIf.res_ready = 1'b0;
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput("holdValid", hostIf.res_valid, 1);
            checkOutput("holdData", hostIf.res_data, exp);
        end
        hostIf.res_ready = 1'b1;
        @(negedge clk);
        hostIf.res_ready = 1'b0;
        checkOutput("validClear", hostIf.res_valid, 0);
        checkOutput("idleAfterDone", busy, 0);
        checkOutput("idleCmd", fab_cmd, 2);
    endtask

    initial begin
        int   nRuns;
        logic [3:0] rndOp;
        reset_n          = 1'b0;
        start            = 1'b0;
        keep_cfg         = 1'b0;
        run_cycles       = 8'h00;
        op_nibble        = 4'h0;
        hostIf.cfg_valid = 1'b0;
        hostIf.cfg_data  = 4'h0;
        hostIf.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstFabCmd", fab_cmd, 2);
        checkOutput("rstFabNibble", fab_nibble, 0);
        checkOutput("rstCfgReady", hostIf.cfg_ready, 0);
        checkOutput("rstResValid", hostIf.res_valid, 0);
        checkOutput("rstResData", hostIf.res_data, 0);
        checkOutput("rstBusy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] back-to-back load, 3 run cycles");
        for (int i = 0; i < 24; i++) bits[i] = 4'($urandom);
        applyStimulus(1'b0, 3, 0, 4'($urandom), 0, 1'b0);

        $display("[TB] load with cfg_valid every other cycle");
        for (int i = 0; i < 24; i++) bits[i] = 4'($urandom);
        applyStimulus(1'b0, 2, 1, 4'($urandom), 1, 1'b0);

        $display("[TB] pass-in1 bitstream, op 0xA, 4 run cycles");
        for (int i = 0; i < 24; i++) bits[i] = (i % 2 == 0) ? 4'h2 : 4'h0;
        applyStimulus(1'b0, 4, 0, 4'hA, 0, 1'b0);
        checkOutput("passIn1", lastRes, 8'hAA);

        $display("[TB] keep_cfg with zero run cycles, result held 5 cycles");
        prevRes = lastRes;
        applyStimulus(1'b1, 0, 0, 4'h5, 5, 1'b0);
        checkOutput("keepZeroPrev", lastRes, prevRes);

        $display("[TB] nibbles 1..24 with start pulsed while running");
        for (int i = 0; i < 24; i++) bits[i] = 4'(i + 1);
        applyStimulus(1'b0, 6, 2, 4'($urandom), 1, 1'b1);
`ifdef MUXPGA_SEQ_CHECKSUM_EN
        checkOutput("cfgSumLiteral", cfg_sum, 4'h8);
`endif

        $display("[TB] reset after 10 nibbles of a load");
        for (int i = 0; i < 24; i++) bits[i] = 4'($urandom);
        start = 1'b1; keep_cfg = 1'b0; run_cycles = 8'd5;
        @(negedge clk);
        start = 1'b0;
        rstSent = 0; rstCycles = 0;
        while (rstSent < 10 && rstCycles < 100) begin
            hostIf.cfg_valid = 1'b1;
            hostIf.cfg_data  = bits[rstSent];
            if (hostIf.cfg_ready) rstSent++;
            @(negedge clk);
            rstCycles++;
        end
        hostIf.cfg_valid = 1'b0;
        checkOutput("midLoadAccepted", rstSent, 10);
        checkOutput("midLoadBusy", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstFabCmd", fab_cmd, 2);
        checkOutput("midRstCfgReady", hostIf.cfg_ready, 0);
        checkOutput("midRstResValid", hostIf.res_valid, 0);
        checkOutput("midRstBusy", busy, 0);
`ifdef MUXPGA_SEQ_CHECKSUM_EN
        checkOutput("midRstCfgSum", cfg_sum, 0);
`endif
        modelSum   = 4'h0;
        chainValid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 12; j++) begin
            case ($urandom_range(0, 4))
                0:       nRuns = 0;
                1:       nRuns = 1;
                4:       nRuns = 255;
                default: nRuns = int'($urandom_range(2, 12));
            endcase
            for (int i = 0; i < 24; i++) bits[i] = 4'($urandom);
            rndOp = 4'($urandom);
            applyStimulus(chainValid && ($urandom_range(0, 1) == 1), nRuns, int'($urandom_range(0, 2)),
                          rndOp, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        finishRun();
    end

endmodule
